// File: rtl/me_column_fetch_pkg.sv
// Shared types and helpers for the motion-estimation fetch path: block geometry,
// pixel/column types, fetch FSM states and the coordinate clamp.
package me_pkg;

    localparam int MACRO_DIM  = 16;
    localparam int SEARCH_DIM = 48;
    localparam int MV_MAX     = (SEARCH_DIM - MACRO_DIM) / 2;
    localparam int IDX_W      = $clog2(MACRO_DIM);
    // Wide enough for 255*MACRO_DIM + MACRO_DIM-1 plus a signed 8-bit displacement.
    localparam int COORD_W    = 14;

    typedef logic [7:0]                  pixel_t;
    typedef pixel_t [0:MACRO_DIM-1]      column_t;
    typedef logic signed [COORD_W-1:0]   coord_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } state_t;

    // Edge-pixel replication: pin a signed coordinate into [0, hi].
    function automatic coord_t clamp_coord(input coord_t v, input coord_t hi);
        coord_t res;
        if (v[COORD_W-1]) begin
            res = '0;
        end else if (v > hi) begin
            res = hi;
        end else begin
            res = v;
        end
        return res;
    endfunction

endpackage

// File: rtl/me_column_fetch_addr_gen.sv
// Turns a block position, motion vector and (col,row) into registered current and
// clamped reference RAM addresses; the read enables follow the issue request.
module me_addr_gen
    import me_pkg::*;
#(
    parameter int IMG_WIDTH  = 16,
    parameter int IMG_HEIGHT = 16,
    parameter int ADDR_W     = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue,
    input  logic [7:0]        mb_x,
    input  logic [7:0]        mb_y,
    input  logic [7:0]        mv_x,
    input  logic [7:0]        mv_y,
    input  logic [IDX_W-1:0]  col,
    input  logic [IDX_W-1:0]  row,
    output logic              cur_rd_en,
    output logic              ref_rd_en,
    output logic [ADDR_W-1:0] cur_addr,
    output logic [ADDR_W-1:0] ref_addr
);

    localparam coord_t            MD_C    = coord_t'(MACRO_DIM);
    localparam coord_t            X_MAX_C = coord_t'(IMG_WIDTH - 1);
    localparam coord_t            Y_MAX_C = coord_t'(IMG_HEIGHT - 1);
    localparam logic [ADDR_W-1:0] WIDTH_A = ADDR_W'(IMG_WIDTH);

    coord_t            cur_x_s;
    coord_t            cur_y_s;
    coord_t            ref_x_s;
    coord_t            ref_y_s;
    logic [ADDR_W-1:0] cur_lin_s;
    logic [ADDR_W-1:0] ref_lin_s;

    // Pixel coordinates and row-major addresses; only the reference side is clamped.
    always_comb begin
        cur_x_s   = coord_t'(mb_x) * MD_C + coord_t'(col);
        cur_y_s   = coord_t'(mb_y) * MD_C + coord_t'(row);
        ref_x_s   = clamp_coord(cur_x_s + coord_t'($signed(mv_x)), X_MAX_C);
        ref_y_s   = clamp_coord(cur_y_s + coord_t'($signed(mv_y)), Y_MAX_C);
        cur_lin_s = ADDR_W'(cur_y_s) * WIDTH_A + ADDR_W'(cur_x_s);
        ref_lin_s = ADDR_W'(ref_y_s) * WIDTH_A + ADDR_W'(ref_x_s);
    end

    // Address/enable registers; the address holds once issuing stops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_rd_en <= 1'b0;
            ref_rd_en <= 1'b0;
            cur_addr  <= '0;
            ref_addr  <= '0;
        end else begin
            cur_rd_en <= issue;
            ref_rd_en <= issue;
            if (issue) begin
                cur_addr <= cur_lin_s;
                ref_addr <= ref_lin_s;
            end
        end
    end

endmodule

// File: rtl/me_column_fetch.sv
// Reads a current macroblock and its displaced reference block from two pixel RAMs
// and streams both column by column, one column strobe every MACRO_DIM cycles.
module me_column_fetch
    import me_pkg::*;
#(
    parameter int IMG_WIDTH  = 16,
    parameter int IMG_HEIGHT = 16,
    parameter int ADDR_W     = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [7:0]                   mb_x,
    input  logic [7:0]                   mb_y,
    input  logic [7:0]                   mv_x,
    input  logic [7:0]                   mv_y,
    output logic                         busy,
    output logic                         done,
    output logic                         cur_rd_en,
    output logic                         ref_rd_en,
    output logic [ADDR_W-1:0]            cur_addr,
    output logic [ADDR_W-1:0]            ref_addr,
    input  logic [7:0]                   cur_data,
    input  logic [7:0]                   ref_data,
    output logic                         en_cpr,
    output logic                         en_spr,
    output logic [0:MACRO_DIM-1][7:0]    pixel_cpr_out,
    output logic [0:MACRO_DIM-1][7:0]    pixel_spr_out
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MACRO_DIM - 1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [7:0]       mb_x_r, mb_y_r, mv_x_r, mv_y_r;
    logic [7:0]       mb_x_nxt_s, mb_y_nxt_s, mv_x_nxt_s, mv_y_nxt_s;
    logic [IDX_W-1:0] col_r, row_r;
    logic [IDX_W-1:0] col_nxt_s, row_nxt_s;
    logic             issue_s;
    logic             ret_vld_r;
    logic [IDX_W-1:0] ret_col_r, ret_row_r;
    column_t          cur_buf_r, ref_buf_r;
    column_t          cur_col_s, ref_col_s;
    logic             col_done_s;
    logic             job_done_s;

    // Return-side events and the outgoing column with the last row bypassed from the RAM bus.
    always_comb begin
        col_done_s = ret_vld_r && (ret_row_r == LAST_IDX);
        job_done_s = col_done_s && (ret_col_r == LAST_IDX);
        cur_col_s  = cur_buf_r;
        ref_col_s  = ref_buf_r;
        cur_col_s[MACRO_DIM-1] = cur_data;
        ref_col_s[MACRO_DIM-1] = ref_data;
    end

    // FSM and read sequencing: next job parameters and (col,row) of the next read.
    always_comb begin
        state_nxt_s = state_r;
        issue_s     = 1'b0;
        col_nxt_s   = col_r;
        row_nxt_s   = row_r;
        mb_x_nxt_s  = mb_x_r;
        mb_y_nxt_s  = mb_y_r;
        mv_x_nxt_s  = mv_x_r;
        mv_y_nxt_s  = mv_y_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_FETCH;
                    issue_s     = 1'b1;
                    col_nxt_s   = '0;
                    row_nxt_s   = '0;
                    mb_x_nxt_s  = mb_x;
                    mb_y_nxt_s  = mb_y;
                    mv_x_nxt_s  = mv_x;
                    mv_y_nxt_s  = mv_y;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (job_done_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
                // Keep issuing back to back until the final (col,row) has been presented.
                if (cur_rd_en && !((col_r == LAST_IDX) && (row_r == LAST_IDX))) begin
                    issue_s = 1'b1;
                    if (row_r == LAST_IDX) begin
                        row_nxt_s = '0;
                        col_nxt_s = col_r + 1'b1;
                    end else begin
                        row_nxt_s = row_r + 1'b1;
                    end
                end else begin
                    issue_s = 1'b0;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Control registers: state, job latch, read counters, return tracking and strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            mb_x_r    <= '0;
            mb_y_r    <= '0;
            mv_x_r    <= '0;
            mv_y_r    <= '0;
            col_r     <= '0;
            row_r     <= '0;
            ret_vld_r <= 1'b0;
            ret_col_r <= '0;
            ret_row_r <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            en_cpr    <= 1'b0;
            en_spr    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            mb_x_r    <= mb_x_nxt_s;
            mb_y_r    <= mb_y_nxt_s;
            mv_x_r    <= mv_x_nxt_s;
            mv_y_r    <= mv_y_nxt_s;
            col_r     <= col_nxt_s;
            row_r     <= row_nxt_s;
            ret_vld_r <= cur_rd_en;
            ret_col_r <= col_r;
            ret_row_r <= row_r;
            busy      <= (state_nxt_s == ST_FETCH);
            done      <= job_done_s;
            en_cpr    <= col_done_s;
            en_spr    <= col_done_s;
        end
    end

    // Gather buffers and output lanes; lanes hold until the next column lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_buf_r     <= '0;
            ref_buf_r     <= '0;
            pixel_cpr_out <= '0;
            pixel_spr_out <= '0;
        end else begin
            if (ret_vld_r) begin
                cur_buf_r[ret_row_r] <= cur_data;
                ref_buf_r[ret_row_r] <= ref_data;
            end
            if (col_done_s) begin
                pixel_cpr_out <= cur_col_s;
                pixel_spr_out <= ref_col_s;
            end
        end
    end

    me_addr_gen #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT),
        .ADDR_W     (ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .issue     (issue_s),
        .mb_x      (mb_x_nxt_s),
        .mb_y      (mb_y_nxt_s),
        .mv_x      (mv_x_nxt_s),
        .mv_y      (mv_y_nxt_s),
        .col       (col_nxt_s),
        .row       (row_nxt_s),
        .cur_rd_en (cur_rd_en),
        .ref_rd_en (ref_rd_en),
        .cur_addr  (cur_addr),
        .ref_addr  (ref_addr)
    );

endmodule

// File: tb/tb_me_column_fetch.sv
// Bench for me_column_fetch on a 48x48 picture: RAM model plus a coordinate-level
// reference of addresses, strobe timing and column contents.
module tb_me_column_fetch;

    localparam int W  = 48;
    localparam int H  = 48;
    localparam int AW = $clog2(W * H);
    localparam int MD = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [7:0]        mb_x, mb_y, mv_x, mv_y;
    logic              busy, done;
    logic              cur_rd_en, ref_rd_en;
    logic [AW-1:0]     cur_addr, ref_addr;
    logic [7:0]        cur_data, ref_data;
    logic              en_cpr, en_spr;
    logic [0:MD-1][7:0] pixel_cpr_out, pixel_spr_out;

    logic [7:0] mem [0:(1<<AW)-1];

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    me_column_fetch #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .mb_x          (mb_x),
        .mb_y          (mb_y),
        .mv_x          (mv_x),
        .mv_y          (mv_y),
        .busy          (busy),
        .done          (done),
        .cur_rd_en     (cur_rd_en),
        .ref_rd_en     (ref_rd_en),
        .cur_addr      (cur_addr),
        .ref_addr      (ref_addr),
        .cur_data      (cur_data),
        .ref_data      (ref_data),
        .en_cpr        (en_cpr),
        .en_spr        (en_spr),
        .pixel_cpr_out (pixel_cpr_out),
        .pixel_spr_out (pixel_spr_out)
    );

    // Single-port RAMs with one cycle of read latency.
    always @(posedge clk) begin
        if (cur_rd_en) cur_data <= mem[cur_addr];
        if (ref_rd_en) ref_data <= mem[ref_addr];
    end

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic int clampi(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    // Picture coordinates of lane r of column c, current or reference block.
    function automatic int px_x(input int mbx, input int mvx, input int c, input bit is_ref);
        return is_ref ? clampi(mbx * MD + c + mvx, W - 1) : (mbx * MD + c);
    endfunction

    function automatic int px_y(input int mby, input int mvy, input int r, input bit is_ref);
        return is_ref ? clampi(mby * MD + r + mvy, H - 1) : (mby * MD + r);
    endfunction

    function automatic logic [127:0] exp_col(input int mbx, input int mby, input int mvx,
                                             input int mvy, input int c, input bit is_ref);
        logic [0:MD-1][7:0] col;
        for (int r = 0; r < MD; r++)
            col[r] = mem[px_y(mby, mvy, r, is_ref) * W + px_x(mbx, mvx, c, is_ref)];
        return col;
    endfunction

    task automatic check_quiet(input string tag);
        check_val({tag, "_ctl"}, 128'({busy, done, en_cpr, en_spr, cur_rd_en, ref_rd_en,
                                       cur_addr, ref_addr}), 128'd0);
        check_val({tag, "_cpr"}, 128'(pixel_cpr_out), 128'd0);
        check_val({tag, "_spr"}, 128'(pixel_spr_out), 128'd0);
    endtask

    // Runs one job starting at the current negedge; n counts edges after the accepting edge.
    task automatic run_job(input int mbx, input int mby, input int mvx, input int mvy,
                           input int disturb_at, input int abort_at);
        logic [5:0] exp_ctl;
        bit         strobe;
        int         c, r;
        mb_x  = 8'(mbx);
        mb_y  = 8'(mby);
        mv_x  = 8'(mvx);
        mv_y  = 8'(mvy);
        start = 1'b1;
        @(posedge clk);
        for (int n = 0; n <= 16 * MD + 1; n++) begin
            @(negedge clk);
            if (n == 0) start = 1'b0;
            if (n == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_quiet("abort");
                return;
            end
            if (n == disturb_at) start = 1'b1;
            if (n == disturb_at + 1) begin
                start = 1'b0;
                mb_x  = mb_x + 8'd1;
                mv_y  = mv_y - 8'd3;
            end
            strobe  = (n >= MD + 1) && (((n - MD - 1) % MD) == 0);
            exp_ctl = {n < MD * MD + 1, n == MD * MD + 1, strobe, strobe, n < MD * MD, n < MD * MD};
            check_val($sformatf("ctl@%0d", n),
                      128'({busy, done, en_cpr, en_spr, cur_rd_en, ref_rd_en}), 128'(exp_ctl));
            if (n < MD * MD) begin
                c = n / MD;
                r = n % MD;
                check_val($sformatf("cur_addr@%0d", n), 128'(cur_addr),
                          128'(px_y(mby, mvy, r, 1'b0) * W + px_x(mbx, mvx, c, 1'b0)));
                check_val($sformatf("ref_addr@%0d", n), 128'(ref_addr),
                          128'(px_y(mby, mvy, r, 1'b1) * W + px_x(mbx, mvx, c, 1'b1)));
            end
            if (strobe) begin
                c = (n - MD - 1) / MD;
                check_val($sformatf("cpr_col%0d", c), 128'(pixel_cpr_out),
                          exp_col(mbx, mby, mvx, mvy, c, 1'b0));
                check_val($sformatf("spr_col%0d", c), 128'(pixel_spr_out),
                          exp_col(mbx, mby, mvx, mvy, c, 1'b1));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        mb_x  = 8'd0;
        mb_y  = 8'd0;
        mv_x  = 8'd0;
        mv_y  = 8'd0;
        for (int i = 0; i < (1 << AW); i++)
            mem[i] = (i < W * H) ? 8'(((i % W) + 3 * (i / W)) % 256) : 8'd0;

        repeat (3) @(negedge clk);
        check_quiet("reset");
        rst_n = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            check_quiet("idle");
        end

        // Directed jobs; each later job starts on the edge right after the previous done.
        run_job(1, 1, 0, 0, -10, -1);
        run_job(1, 1, -16, 5, -10, -1);
        run_job(0, 0, -16, -16, -10, -1);
        run_job(2, 2, 16, 16, -10, -1);
        run_job(1, 0, 3, -7, 39, -1);

        @(negedge clk);
        run_job(2, 1, -5, 9, -10, 100);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_quiet("in_reset");
        end
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check_val("post_reset_ctl", 128'({busy, done, en_cpr, en_spr, cur_rd_en}), 128'd0);
        end
        run_job(2, 1, -5, 9, -10, -1);

        for (int i = 0; i < W * H; i++) mem[i] = 8'($urandom);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            run_job(int'($urandom_range(2, 0)), int'($urandom_range(2, 0)),
                    int'($urandom_range(32, 0)) - 16, int'($urandom_range(32, 0)) - 16, -10, -1);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/me_column_fetch.md
# me_column_fetch

Frame-memory reader that feeds the motion-estimation core. On a start request it reads one MACRO_DIM×MACRO_DIM current macroblock and the co-sized reference block displaced by a motion vector from two single-port pixel RAMs. It streams both blocks column by column on the `en_cpr`/`en_spr` + `pixel_cpr_*`/`pixel_spr_*` interface that `me` consumes. It replaces the bench-side stimulus loop with synthesizable RTL and sits between the frame buffers and `me`.

## Interface
- IMG_WIDTH, 16, picture width in pixels (multiple of MACRO_DIM)
- IMG_HEIGHT, 16, picture height in pixels (multiple of MACRO_DIM)
- MACRO_DIM, 16, block edge; lanes per output column
- SEARCH_DIM, 48, search window edge; legal mv range ±(SEARCH_DIM−MACRO_DIM)/2
- ADDR_W, $clog2(IMG_WIDTH*IMG_HEIGHT), RAM address width (derived)

Ports:
- clk  in  1  clock; all logic is rising-edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request pulse; sampled only in IDLE
- mb_x, mb_y  in  8  macroblock column/row index
- mv_x, mv_y  in  8 signed  reference displacement in pixels
- busy  out  1  high from accepted start through last column
- done  out  1  one-cycle pulse coincident with last column strobe
- cur_rd_en, ref_rd_en  out  1  RAM read enables
- cur_addr, ref_addr  out  ADDR_W  row-major address y*IMG_WIDTH+x
- cur_data, ref_data  in  8  RAM read data, 1-cycle latency
- en_cpr, en_spr  out  1  column-valid strobes (always equal)
- pixel_cpr_out, pixel_spr_out  out  [0:MACRO_DIM-1][7:0]  column lanes; lane r = block row r

## Operation
- FSM: IDLE → FETCH on start; FETCH → IDLE when the column MACRO_DIM−1 strobe issues.
- Accepted start registers mb_x, mb_y, mv_x, mv_y. Later input changes have no effect. start during FETCH is ignored.
- FETCH walks col c = 0..MACRO_DIM−1 (outer) and row r = 0..MACRO_DIM−1 (inner). It issues one read per cycle on both RAMs with no bubbles, including between columns.
- Current coordinates: x = mb_x*MACRO_DIM + c, y = mb_y*MACRO_DIM + r. Never clamped.
- Reference coordinates are x + mv_x and y + mv_y, computed in signed arithmetic at least 12 bits wide. Each is clamped to [0, IMG_WIDTH−1] / [0, IMG_HEIGHT−1] (edge-pixel replication).
- Returned data is collected into a MACRO_DIM-entry gather buffer per picture. When row MACRO_DIM−1 data returns, the full column is copied into the output registers and en_* is pulsed.
- Output lanes hold their value until the next column copy. They are not cleared at job end.
- Reset (any time, including mid-FETCH): state IDLE; busy, done, en_*, *_rd_en = 0; addresses, lanes and counters = 0. Any partial job is discarded.

## Timing
- Edge E0 accepts start. busy is high after E0.
- rd_en is high and the address for (c, r) is valid from E(1+16c+r)−1 to E(1+16c+r), generalised with MACRO_DIM. Data for that read is captured at E(2+MACRO_DIM·c+r).
- en_* is high for exactly one cycle after E(MACRO_DIM+1+MACRO_DIM·c). With the default MACRO_DIM the strobes land at E17, E33, …, E257.
- done pulses with the final strobe. busy and rd_en fall at that same edge. A new start is accepted from the next edge (E258 with the defaults).
- Column period is exactly MACRO_DIM cycles. `me` needs no backpressure, so there is no stall input.

## Structure
- Package me_pkg: MACRO_DIM, SEARCH_DIM, pixel_t (logic [7:0]), column_t (pixel_t [0:MACRO_DIM-1]), the fsm state enum, and a clamp function shared with future search-window logic.
- Sub-module me_addr_gen: combinational-plus-register coordinate and clamp computation producing both addresses and rd_en. The top module holds the FSM, counters, gather buffers and output registers.

## Test plan
- Reset, then no start: all outputs 0 for 50 cycles, and no rd_en.
- IMG 48×48, mb (1,1), mv (0,0), RAM pixel = (x+3y) mod 256: first strobe at E17 with lane r = (16+3(16+r)) mod 256; 16 strobes; cur and spr lanes identical; done at E257.
- Same setup, mv (−16, +5): ref lane r of col c = pixel(c, 21+r), and first ref_addr = 21*48.
- Corner clamp: mb (0,0), mv (−16, −16) on IMG 16×16: every spr lane equals pixel(0,0). mv (+16,+16): every spr lane equals pixel(15,15).
- start re-pulsed at E40 and mb_x changed at E41: stream unchanged, one done. start at E258 accepted, next first strobe at E275.
- rst_n low at E100 mid-job: outputs 0 asynchronously, no further strobes. Fresh start after release is fully correct.
